segment_scan_decoder: RTL and testbench
=======================================

Name: segment_scan_decoder

Overview:
- Receive-side counterpart of the multiplexed 3-digit 7-segment driver.
- Snoops the scanned, active-low segment bus and the one-hot select lines.
- Filters the scan transitions, decodes each digit pattern back to a hex nibble plus a decimal-point flag, and reassembles the full 12-bit value and 3-bit dp word.
- Used as a loopback and readback monitor on the miner board and as a scoreboard front-end in simulation.

Parameters:
- STABLE_CYCLES, 8: number of consecutive identical samples required before a digit is accepted. Legal range 1..65535.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- segment  in  8  active-low; bit7 = dp (0 = lit), bits6:0 = gfedcba
- select  in  3  one-hot digit enable; bit0 = digit 0 (data[3:0])
- data  out  12  last complete decoded value; digit n in [4n+3:4n]
- dp  out  3  last complete dp word; 1 = point lit
- frame_valid  out  1  one-cycle pulse when data/dp update
- bad_pattern  out  1  one-cycle pulse on a stable, unknown 7-bit pattern
- digit_mask  out  3  digits captured so far in the current frame

Behaviour:
- Reset (synchronous, rst high at edge):
  - data=0, dp=0, frame_valid=0, bad_pattern=0, digit_mask=0.
  - Shadow registers = 0; stability counter = 0.
  - Sample register = {select=3'b000, segment=8'hFF}.
- Input stage:
  - {select, segment} registered every edge into sample S.
  - No other logic uses the pins directly.
- Stability counter C, saturating at STABLE_CYCLES:
  - C=0 on any edge where the new sample differs from S.
  - Otherwise C increments, up to STABLE_CYCLES.
- Capture event:
  - Occurs on the edge where C == STABLE_CYCLES-1 and the incoming sample equals S.
  - If the pins hold a value from the edge that first samples it (e0), all effects are visible after edge e0+STABLE_CYCLES.
  - Exactly one capture per stable window, because C saturates at STABLE_CYCLES.
  - A value held for only STABLE_CYCLES-1 edges after e0 is never captured.
- On capture, if S.select is not one-hot (000 or multi-hot): ignored. No mask change, no bad_pattern.
- On capture with one-hot select, slot k, S.segment[6:0] is decoded against this table:
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, B:03, C:46, D:21, E:06, F:0E
- Unknown pattern (includes blank 7F): bad_pattern=1 for one cycle; slot not marked; shadow unchanged.
- Known pattern:
  - shadow_nib[k] = decoded nibble; shadow_dp[k] = ~S.segment[7].
  - digit_mask[k] set.
  - Re-capturing an already-set slot overwrites its shadow (latest wins); mask unchanged.
- Frame completion:
  - On the capture edge that makes digit_mask == 3'b111, data/dp load from the shadow including the new digit, in the same edge.
  - frame_valid=1 for that one cycle.
  - digit_mask clears to 0 in that same edge.
  - Output digit_mask never reads 3'b111.
- data/dp hold between frames.
- No capture ordering is required: digits may arrive in any order.
- rst mid-frame: partial frame discarded; data/dp cleared to 0.
- frame_valid and bad_pattern are mutually exclusive; each is 0 in every cycle without a qualifying capture.

Decomposition:
- Shared package:
  - The 16 seven-bit digit pattern constants, shared with the segment encoder so the two ends cannot diverge.
  - SEG_BLANK = 8'hFF.
  - Digit count 3.
- Sub-module segment_pattern_decoder:
  - Purely combinational, 7-bit pattern -> {hit, nibble[3:0]}.
  - Instantiated once on S.segment[6:0].

Test Plan:
1. STABLE_CYCLES=8. Drive sel=001/seg=8'h99, then sel=010/seg=8'h30, then sel=100/seg=8'h8E, 20 cycles each -> exactly one frame_valid pulse; data=12'hF34, dp=3'b010; digit_mask goes 001, 011, then 000.
2. Timing: new value first sampled at edge e0 -> digit_mask bit visible after edge e0+8. Same value held 7 edges then changed -> no capture, mask stays 000.
3. sel=010/seg=8'hFF held 12 cycles -> single one-cycle bad_pattern pulse; digit_mask and shadow unchanged. Then sel=011/seg=8'hC0 held 20 cycles -> no effect at all.
4. Capture digits 0 and 1, assert rst for one cycle, then supply digit 2 only -> no frame_valid; digit_mask=100; data=0.
5. Slot overwrite: sel=001/seg=8'hC0, then sel=001/seg=8'hF9, then slots 1 and 2 -> data[3:0]=1 and one frame_valid.
6. Loopback: segment driver with data=12'hA5C, dp=3'b101, free running for 5 scans -> frame_valid once per scan, data=12'hA5C, dp=3'b101, no bad_pattern.

Source files
------------

// File: rtl/segment_scan_decoder_pkg.sv
// Shared definitions for the multiplexed 3-digit 7-segment bus: digit count,
// blank code, the sample record and the hex-to-pattern table.
package segment_scan_decoder_pkg;

  localparam int NUM_DIGITS = 3;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef struct packed {
    logic [NUM_DIGITS-1:0] select;
    logic [7:0]            segment;
  } scan_sample_t;

  // Active-low gfedcba pattern for each hex digit; the encoder uses the same table.
  function automatic logic [6:0] seg_pattern(input logic [3:0] nibble);
    logic [6:0] pat;
    case (nibble)
      4'h0: pat = 7'h40;
      4'h1: pat = 7'h79;
      4'h2: pat = 7'h24;
      4'h3: pat = 7'h30;
      4'h4: pat = 7'h19;
      4'h5: pat = 7'h12;
      4'h6: pat = 7'h02;
      4'h7: pat = 7'h78;
      4'h8: pat = 7'h00;
      4'h9: pat = 7'h10;
      4'hA: pat = 7'h08;
      4'hB: pat = 7'h03;
      4'hC: pat = 7'h46;
      4'hD: pat = 7'h21;
      4'hE: pat = 7'h06;
      default: pat = 7'h0E;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/segment_scan_decoder_pattern.sv
// Combinational reverse lookup of a 7-bit active-low segment pattern to a hex
// nibble; hit is low for any pattern outside the 16-entry table (blank included).
module segment_pattern_decoder
  import segment_scan_decoder_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       hit,
  output logic [3:0] nibble
);

  always_comb begin
    hit    = 1'b0;
    nibble = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (pattern == seg_pattern(4'(i))) begin
        hit    = 1'b1;
        nibble = 4'(i);
      end
    end
  end

endmodule

// File: rtl/segment_scan_decoder.sv
// Snoops a scanned 7-segment bus, accepts each digit once it has been stable
// long enough, and publishes the reassembled 12-bit value when all digits are seen.
module segment_scan_decoder
  import segment_scan_decoder_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [7:0]                segment,
  input  logic [NUM_DIGITS-1:0]     select,
  output logic [4*NUM_DIGITS-1:0]   data,
  output logic [NUM_DIGITS-1:0]     dp,
  output logic                      frame_valid,
  output logic                      bad_pattern,
  output logic [NUM_DIGITS-1:0]     digit_mask
);

  localparam logic [15:0] CNT_MAX = 16'(STABLE_CYCLES);
  localparam logic [15:0] CNT_CAP = 16'(STABLE_CYCLES - 1);

  scan_sample_t                pins;
  scan_sample_t                sample;
  logic [15:0]                 stable_cnt;
  logic [4*NUM_DIGITS-1:0]     shadow_data;
  logic [NUM_DIGITS-1:0]       shadow_dp;
  logic [4*NUM_DIGITS-1:0]     next_data;
  logic [NUM_DIGITS-1:0]       next_dp;
  logic [NUM_DIGITS-1:0]       next_mask;
  logic                        same;
  logic                        capture;
  logic                        one_hot;
  logic                        pat_hit;
  logic [3:0]                  pat_nibble;

  assign pins    = '{select: select, segment: segment};
  assign same    = (pins == sample);
  // Counter saturates at CNT_MAX, so this fires exactly once per stable window.
  assign capture = same && (stable_cnt == CNT_CAP);
  assign one_hot = (sample.select != '0) &&
                   ((sample.select & (sample.select - 1'b1)) == '0);

  segment_pattern_decoder u_pattern (
    .pattern (sample.segment[6:0]),
    .hit     (pat_hit),
    .nibble  (pat_nibble)
  );

  // Shadow contents with the digit being captured merged in.
  always_comb begin
    next_data = shadow_data;
    next_dp   = shadow_dp;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sample.select[i]) begin
        next_data[4*i +: 4] = pat_nibble;
        next_dp[i]          = ~sample.segment[7];
      end
    end
    next_mask = digit_mask | sample.select;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sample      <= '{select: '0, segment: SEG_BLANK};
      stable_cnt  <= '0;
      shadow_data <= '0;
      shadow_dp   <= '0;
      data        <= '0;
      dp          <= '0;
      frame_valid <= 1'b0;
      bad_pattern <= 1'b0;
      digit_mask  <= '0;
    end else begin
      sample      <= pins;
      frame_valid <= 1'b0;
      bad_pattern <= 1'b0;

      if (!same) begin
        stable_cnt <= '0;
      end else if (stable_cnt != CNT_MAX) begin
        stable_cnt <= stable_cnt + 16'd1;
      end

      if (capture && one_hot) begin
        if (!pat_hit) begin
          bad_pattern <= 1'b1;
        end else begin
          shadow_data <= next_data;
          shadow_dp   <= next_dp;
          if (&next_mask) begin
            data        <= next_data;
            dp          <= next_dp;
            frame_valid <= 1'b1;
            digit_mask  <= '0;
          end else begin
            digit_mask  <= next_mask;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_segment_scan_decoder.sv
// Bench for segment_scan_decoder: scripted vector table, hand-written timing and
// loopback sequences, then random scans checked every cycle against a run-length model.
module tb_segment_scan_decoder;

  localparam int STABLE = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  segment = 8'hFF;
  logic [2:0]  select = 3'b000;
  logic [11:0] data;
  logic [2:0]  dp;
  logic        frame_valid;
  logic        bad_pattern;
  logic [2:0]  digit_mask;

  segment_scan_decoder #(.STABLE_CYCLES(STABLE)) dut (
    .clk         (clk),
    .rst         (rst),
    .segment     (segment),
    .select      (select),
    .data        (data),
    .dp          (dp),
    .frame_valid (frame_valid),
    .bad_pattern (bad_pattern),
    .digit_mask  (digit_mask)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int fv_seen = 0;
  int bad_seen = 0;

  logic [6:0] pat_tab [16];

  // Reference model state: run length of the current pin value, plus per-slot shadows.
  logic [10:0] m_last;
  bit          m_last_valid;
  int          m_run;
  int          m_nib [3];
  bit          m_dpv [3];
  bit          m_seen [3];
  logic [11:0] exp_data;
  logic [2:0]  exp_dp;
  logic [2:0]  exp_mask;
  bit          exp_fv;
  bit          exp_bad;

  typedef struct {
    bit         do_rst;
    logic [2:0] sel;
    logic [7:0] seg;
    int         cycles;
    logic [2:0] mask;
    logic [11:0] data;
    logic [2:0] dp;
    int         fv;
    int         bad;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int lookup(input logic [6:0] p);
    for (int i = 0; i < 16; i++) if (pat_tab[i] == p) return i;
    return -1;
  endfunction

  task automatic model_edge(input bit r, input logic [10:0] p);
    int ones;
    int k;
    int nib;
    exp_fv  = 0;
    exp_bad = 0;
    if (r) begin
      m_last_valid = 0;
      m_run = 0;
      for (int i = 0; i < 3; i++) begin
        m_nib[i] = 0; m_dpv[i] = 0; m_seen[i] = 0;
      end
      exp_data = '0;
      exp_dp = '0;
    end else begin
      if (m_last_valid && p == m_last) m_run++;
      else m_run = 1;
      m_last = p;
      m_last_valid = 1;
      if (m_run == STABLE + 1) begin
        ones = 0;
        k = 0;
        for (int i = 0; i < 3; i++) if (p[8+i]) begin ones++; k = i; end
        if (ones == 1) begin
          nib = lookup(p[6:0]);
          if (nib < 0) begin
            exp_bad = 1;
          end else begin
            m_nib[k] = nib;
            m_dpv[k] = !p[7];
            m_seen[k] = 1;
            if (m_seen[0] && m_seen[1] && m_seen[2]) begin
              exp_data = {m_nib[2][3:0], m_nib[1][3:0], m_nib[0][3:0]};
              exp_dp = {m_dpv[2], m_dpv[1], m_dpv[0]};
              exp_fv = 1;
              for (int i = 0; i < 3; i++) m_seen[i] = 0;
            end
          end
        end
      end
    end
    exp_mask = {m_seen[2], m_seen[1], m_seen[0]};
  endtask

  task automatic step(input bit r, input logic [2:0] s, input logic [7:0] g);
    rst = r;
    select = s;
    segment = g;
    @(posedge clk);
    model_edge(r, {s, g});
    #1;
    chk("model data", int'(data), int'(exp_data));
    chk("model dp", int'(dp), int'(exp_dp));
    chk("model digit_mask", int'(digit_mask), int'(exp_mask));
    chk("model frame_valid", int'(frame_valid), int'(exp_fv));
    chk("model bad_pattern", int'(bad_pattern), int'(exp_bad));
    if (frame_valid) fv_seen++;
    if (bad_pattern) bad_seen++;
  endtask

  task automatic hold(input logic [2:0] s, input logic [7:0] g, input int n);
    for (int c = 0; c < n; c++) step(1'b0, s, g);
  endtask

  task automatic do_reset();
    step(1'b1, 3'b000, 8'hFF);
    step(1'b1, 3'b000, 8'hFF);
  endtask

  initial begin
    logic [11:0] lb_data;
    logic [2:0]  lb_dp;
    logic [2:0]  rs;
    logic [7:0]  rg;
    int          r;
    int          len;

    pat_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // rst, sel, seg, cycles, mask, data, dp, frame_valid pulses, bad_pattern pulses
    vecs.push_back('{0, 3'b001, 8'h99, 20, 3'b001, 12'h000, 3'b000, 0, 0});
    vecs.push_back('{0, 3'b010, 8'h30, 20, 3'b011, 12'h000, 3'b000, 0, 0});
    vecs.push_back('{0, 3'b100, 8'h8E, 20, 3'b000, 12'hF34, 3'b010, 1, 0});
    vecs.push_back('{0, 3'b010, 8'hFF, 12, 3'b000, 12'hF34, 3'b010, 0, 1});
    vecs.push_back('{0, 3'b011, 8'hC0, 20, 3'b000, 12'hF34, 3'b010, 0, 0});
    vecs.push_back('{0, 3'b001, 8'hC0, 20, 3'b001, 12'hF34, 3'b010, 0, 0});
    vecs.push_back('{0, 3'b001, 8'hF9, 20, 3'b001, 12'hF34, 3'b010, 0, 0});
    vecs.push_back('{0, 3'b010, 8'hA4, 20, 3'b011, 12'hF34, 3'b010, 0, 0});
    vecs.push_back('{0, 3'b100, 8'hB0, 20, 3'b000, 12'h321, 3'b000, 1, 0});
    vecs.push_back('{0, 3'b001, 8'hC0, 20, 3'b001, 12'h321, 3'b000, 0, 0});
    vecs.push_back('{0, 3'b010, 8'hF9, 20, 3'b011, 12'h321, 3'b000, 0, 0});
    vecs.push_back('{1, 3'b010, 8'hF9,  1, 3'b000, 12'h000, 3'b000, 0, 0});
    vecs.push_back('{0, 3'b100, 8'hA4, 20, 3'b100, 12'h000, 3'b000, 0, 0});

    do_reset();
    chk("reset data", int'(data), 0);
    chk("reset dp", int'(dp), 0);
    chk("reset digit_mask", int'(digit_mask), 0);
    chk("reset frame_valid", int'(frame_valid), 0);
    chk("reset bad_pattern", int'(bad_pattern), 0);

    foreach (vecs[i]) begin
      fv_seen = 0;
      bad_seen = 0;
      for (int c = 0; c < vecs[i].cycles; c++) step(vecs[i].do_rst, vecs[i].sel, vecs[i].seg);
      chk($sformatf("row%0d digit_mask", i), int'(digit_mask), int'(vecs[i].mask));
      chk($sformatf("row%0d data", i), int'(data), int'(vecs[i].data));
      chk($sformatf("row%0d dp", i), int'(dp), int'(vecs[i].dp));
      chk($sformatf("row%0d frame_valid pulses", i), fv_seen, vecs[i].fv);
      chk($sformatf("row%0d bad_pattern pulses", i), bad_seen, vecs[i].bad);
    end

    // Capture latency: value first sampled at e0 shows in digit_mask after e0+STABLE.
    do_reset();
    for (int c = 0; c < STABLE; c++) begin
      step(1'b0, 3'b001, 8'hC0);
      chk($sformatf("latency mask before capture e0+%0d", c), int'(digit_mask), 0);
    end
    step(1'b0, 3'b001, 8'hC0);
    chk("latency mask at e0+STABLE", int'(digit_mask), 1);

    // A value held one edge short of the window is never captured.
    do_reset();
    hold(3'b010, 8'hF9, STABLE - 1);
    hold(3'b000, 8'hFF, 12);
    chk("short hold digit_mask", int'(digit_mask), 0);

    // Loopback against a free-running 3-digit scan of 12'hA5C / dp 101.
    do_reset();
    lb_data = 12'hA5C;
    lb_dp = 3'b101;
    fv_seen = 0;
    bad_seen = 0;
    for (int s = 0; s < 5; s++) begin
      for (int d = 0; d < 3; d++) begin
        hold(3'(1 << d), {~lb_dp[d], pat_tab[lb_data[4*d +: 4]]}, 12);
      end
    end
    chk("loopback frame_valid pulses", fv_seen, 5);
    chk("loopback bad_pattern pulses", bad_seen, 0);
    chk("loopback data", int'(data), 12'hA5C);
    chk("loopback dp", int'(dp), 3'b101);

    // Random scan traffic; hold lengths straddle the stability window.
    do_reset();
    for (int t = 0; t < 300; t++) begin
      r = $urandom_range(0, 11);
      case (r)
        0: rs = 3'b000;
        1: rs = 3'b011;
        2: rs = 3'b110;
        default: rs = 3'(1 << (r % 3));
      endcase
      if ($urandom_range(0, 3) == 0) rg = 8'($urandom);
      else rg = {1'($urandom), pat_tab[$urandom_range(0, 15)]};
      len = $urandom_range(1, 14);
      if ($urandom_range(0, 40) == 0) step(1'b1, rs, rg);
      hold(rs, rg, len);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
